// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS instruction fetch with single-outstanding imem read and a small PC/instruction queue.
// Optional macro IF_ALIGN_CHK_EN: misaligned PCs skip memory and queue an address-error entry.
module if_fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              flush,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_exc,
    input  logic              inst_ready,
    output logic              busy
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_rd, r_wr;
    logic [DATA_W-1:0] r_q_data [QDEPTH];
    logic [ADDR_W-1:0] r_q_pc   [QDEPTH];
    logic              w_accept, w_fetch, w_pop, w_push_mem, w_push_exc, w_push;
    assign w_accept   = pc_valid && pc_ready;
    assign w_pop      = inst_valid && inst_ready;
    assign w_push_mem = (r_state == WAIT) && imem_rvalid && !flush;
    assign w_push     = w_push_mem || w_push_exc;
`ifdef IF_ALIGN_CHK_EN
    logic r_exc_pend;
    logic r_q_exc [QDEPTH];
    assign w_fetch    = w_accept && (pc_in[1:0] == 2'b00);
    assign w_push_exc = r_exc_pend;
    assign pc_ready   = (r_state == IDLE) && (r_count < CW'(QDEPTH)) && !flush && !r_exc_pend;
    assign inst_exc   = r_q_exc[r_rd];
    // A misaligned accept is remembered for one cycle, then queued as an error entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_exc_pend <= 1'b0;
        else      r_exc_pend <= !flush && w_accept && !w_fetch;
    end
    // Error flag storage alongside each queue entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) for (int i = 0; i < QDEPTH; i++) r_q_exc[i] <= 1'b0;
        else if (!flush && w_push) r_q_exc[r_wr] <= w_push_exc;
    end
`else
    assign w_fetch    = w_accept;
    assign w_push_exc = 1'b0;
    assign pc_ready   = (r_state == IDLE) && (r_count < CW'(QDEPTH)) && !flush;
    assign inst_exc   = 1'b0;
`endif
    assign inst_valid = r_count != '0;
    assign inst_out   = r_q_data[r_rd];
    assign inst_pc    = r_q_pc[r_rd];
    assign imem_addr  = r_addr;
    // State register and request address latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) r_addr <= pc_in;
        end
    end
    // Next state: flush with a grant or mid-wait must still swallow the pending response
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: w_next = w_fetch ? REQ : IDLE;
            REQ:  w_next = imem_gnt ? (flush ? DROP : WAIT) : (flush ? IDLE : REQ);
            WAIT: w_next = imem_rvalid ? IDLE : (flush ? DROP : WAIT);
            DROP: w_next = imem_rvalid ? IDLE : DROP;
        endcase
    end
    // Outputs decoded from state
    always_comb begin
        imem_req = r_state == REQ;
        busy     = r_state != IDLE;
    end
    // Instruction queue; flush wins over push and pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else if (flush) begin
            r_count <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
        end else begin
            if (w_push) begin
                r_q_data[r_wr] <= w_push_mem ? imem_rdata : '0;
                r_q_pc[r_wr]   <= r_addr;
                r_wr           <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed and randomized checks of if_fetch_unit against a transaction-level queue model.
module tb_if_fetch_unit;
    localparam int QD = 2;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] d;
        logic        e;
    } ent_t;
    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] pc_in = '0, imem_addr, imem_rdata = '0, inst_out, inst_pc;
    logic        pc_valid = 1'b0, pc_ready, imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic        flush = 1'b0, inst_valid, inst_exc, inst_ready = 1'b0, busy;
    int          vectors = 0, errors = 0;
    ent_t        mq[$];
    int          m_phase = 0;
    int          m_delay = 0;
    logic [31:0] m_addr = '0;
    bit          m_exc_pend = 1'b0;

    if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .flush(flush),
        .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
        .inst_exc(inst_exc), .inst_ready(inst_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mready();
        return m_phase == 0 && mq.size() < QD && !flush && !m_exc_pend;
    endfunction

    function automatic bit misaligned(input logic [31:0] pc);
`ifdef IF_ALIGN_CHK_EN
        return pc[1:0] != 2'b00;
`else
        return pc[1:0] != 2'b00 && 1'b0;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_phase = 0;
        m_delay = 0;
        m_exc_pend = 1'b0;
    endtask

    // Phases: 0 nothing outstanding, 1 awaiting grant, 2 awaiting data, 3 data will be thrown away
    task automatic model_update();
        bit acc;
        acc = pc_valid && mready();
        if (flush) begin
            mq.delete();
            m_exc_pend = 1'b0;
        end else begin
            if (mq.size() > 0 && inst_ready) void'(mq.pop_front());
            if (m_exc_pend) mq.push_back('{m_addr, 32'h0, 1'b1});
            m_exc_pend = 1'b0;
        end
        case (m_phase)
            0: if (acc) begin
                m_addr = pc_in;
                if (misaligned(pc_in)) m_exc_pend = 1'b1;
                else m_phase = 1;
            end
            1: if (imem_gnt) begin
                m_phase = flush ? 3 : 2;
                m_delay = $urandom_range(0, 3);
            end else if (flush) m_phase = 0;
            2: if (imem_rvalid) begin
                if (!flush) mq.push_back('{m_addr, imem_rdata, 1'b0});
                m_phase = 0;
            end else begin
                if (flush) m_phase = 3;
                if (m_delay > 0) m_delay--;
            end
            default: if (imem_rvalid) m_phase = 0;
                     else if (m_delay > 0) m_delay--;
        endcase
    endtask

    task automatic compare();
        chk("pc_ready", pc_ready, mready());
        chk("imem_req", imem_req, m_phase == 1);
        chk("busy", busy, m_phase != 0);
        chk("inst_valid", inst_valid, mq.size() > 0);
        if (m_phase == 1) chk("imem_addr", imem_addr, m_addr);
        if (mq.size() > 0) begin
            chk("inst_pc", inst_pc, mq[0].pc);
            chk("inst_out", inst_out, mq[0].d);
            chk("inst_exc", inst_exc, mq[0].e);
        end
    endtask

    task automatic step();
        #1 compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_in();
        pc_valid = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] data);
        pc_valid = 1'b1;
        pc_in = pc;
        step();
        pc_valid = 1'b0;
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = data;
        step();
        imem_rvalid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst imem_req", imem_req, 0);
        chk("rst imem_addr", imem_addr, 0);
        chk("rst inst_valid", inst_valid, 0);
        chk("rst inst_out", inst_out, 0);
        chk("rst inst_pc", inst_pc, 0);
        chk("rst inst_exc", inst_exc, 0);
        chk("rst busy", busy, 0);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        // single fetch with minimum latency
        pc_valid = 1'b1;
        pc_in = 32'h00400000;
        #1 chk("first pc_ready", pc_ready, 1);
        step();
        pc_valid = 1'b0;
        chk("c1 imem_req", imem_req, 1);
        chk("c1 imem_addr", imem_addr, 32'h00400000);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("c2 inst_valid", inst_valid, 0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h3C010040;
        step();
        imem_rvalid = 1'b0;
        chk("c3 inst_valid", inst_valid, 1);
        chk("c3 inst_out", inst_out, 32'h3C010040);
        chk("c3 inst_pc", inst_pc, 32'h00400000);
        inst_ready = 1'b1;
        step();
        chk("drained", inst_valid, 0);
        // backpressure fills the queue
        inst_ready = 1'b0;
        fetch(32'h00400000, 32'h11111111);
        fetch(32'h00400004, 32'h22222222);
        pc_valid = 1'b1;
        pc_in = 32'h00400008;
        #1 chk("full pc_ready", pc_ready, 0);
        step();
        chk("full imem_req", imem_req, 0);
        pc_valid = 1'b0;
        inst_ready = 1'b1;
        step();
        chk("after pop pc_ready", pc_ready, 1);
        chk("after pop inst_pc", inst_pc, 32'h00400004);
        step();
        // delayed grant
        inst_ready = 1'b0;
        pc_valid = 1'b1;
        pc_in = 32'h00400004;
        step();
        pc_valid = 1'b0;
        repeat (4) begin
            chk("dly imem_req", imem_req, 1);
            chk("dly imem_addr", imem_addr, 32'h00400004);
            step();
        end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h8C220000;
        step();
        imem_rvalid = 1'b0;
        chk("dly inst_pc", inst_pc, 32'h00400004);
        chk("dly inst_out", inst_out, 32'h8C220000);
        inst_ready = 1'b1;
        step();
        chk("dly single push", inst_valid, 0);
        // flush while waiting on data
        pc_valid = 1'b1;
        pc_in = 32'h00400010;
        step();
        pc_valid = 1'b0;
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        step();
        imem_rvalid = 1'b0;
        chk("flushed data dropped", inst_valid, 0);
        chk("flushed busy", busy, 0);
        inst_ready = 1'b0;
        fetch(32'h00400100, 32'h24020001);
        chk("redirect inst_pc", inst_pc, 32'h00400100);
        chk("redirect inst_out", inst_out, 32'h24020001);
        // flush against simultaneous push and pop at count=1
        pc_valid = 1'b1;
        pc_in = 32'h00400104;
        step();
        pc_valid = 1'b0;
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        inst_ready = 1'b1;
        flush = 1'b1;
        step();
        idle_in();
        chk("flush push pop inst_valid", inst_valid, 0);
        chk("flush push pop busy", busy, 0);
`ifdef IF_ALIGN_CHK_EN
        inst_ready = 1'b0;
        pc_valid = 1'b1;
        pc_in = 32'h00400002;
        step();
        pc_valid = 1'b0;
        chk("mis imem_req", imem_req, 0);
        step();
        chk("mis inst_valid", inst_valid, 1);
        chk("mis inst_exc", inst_exc, 1);
        chk("mis inst_pc", inst_pc, 32'h00400002);
        chk("mis inst_out", inst_out, 0);
        inst_ready = 1'b1;
        step();
`endif
        // randomized traffic with a mid-run asynchronous reset
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) begin
                idle_in();
                rst = 1'b0;
                #1;
                chk("async rst busy", busy, 0);
                chk("async rst inst_valid", inst_valid, 0);
                chk("async rst imem_req", imem_req, 0);
                model_reset();
                @(negedge clk);
                rst = 1'b1;
            end
            pc_valid = $urandom_range(0, 1);
            pc_in = {20'h00400, 10'($urandom_range(0, 1023)), 2'b00};
`ifdef IF_ALIGN_CHK_EN
            if ($urandom_range(0, 3) == 0) pc_in[1:0] = 2'($urandom_range(1, 3));
`endif
            inst_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 15) == 0;
            imem_gnt = m_phase == 1 && $urandom_range(0, 2) != 0;
            imem_rvalid = (m_phase >= 2) ? (m_delay == 0) : ($urandom_range(0, 7) == 0);
            imem_rdata = $urandom;
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
